tuser_out_fsm: RTL

Packet/tuple re-merge stage placed directly downstream of the SDNet core, symmetric to the ingress tuser splitter. It takes the SDNet output packet stream (AXIS, no tuser) and the per-packet output tuple (valid pulse, no backpressure). It buffers tuples in a small FIFO and re-attaches each tuple to the `tuser` of the first beat of the matching packet. The result is an AXIS stream with tuser toward the NetFPGA output queues. Packets and tuples are paired strictly in arrival order.

---
 rtl/tuser_pkg.sv | 18 +
 rtl/tuple_fifo.sv | 69 ++++++
 rtl/tuser_out_fsm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tuser_pkg.sv
// Shared definitions for the tuser splitter/merger pair around the SDNet core.
package tuser_pkg;

  localparam int unsigned DATA_W  = 256;
  localparam int unsigned KEEP_W  = DATA_W / 8;
  localparam int unsigned TUSER_W = 128;

  // State encoding shared with the ingress splitter; 3'b011..3'b111 behave as ST_WAIT.
  localparam logic [2:0] ST_WAIT = 3'b000;
  localparam logic [2:0] ST_HEAD = 3'b001;
  localparam logic [2:0] ST_BODY = 3'b010;

  // True while a packet may be accepted (tuple available or mid-packet).
  function automatic logic st_is_active(input logic [2:0] st);
    return (st == ST_HEAD) || (st == ST_BODY);
  endfunction

endpackage

// File: rtl/tuple_fifo.sv
// Small synchronous FIFO holding per-packet tuples until their packet's first beat arrives.
// A push while full is only accepted when a pop happens in the same cycle.
module tuple_fifo
  import tuser_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Flags, qualified push/pop and pointer/count next-state.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only read while non-empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/tuser_out_fsm.sv
// Re-merges the SDNet output tuple onto tuser of the first beat of the matching packet.
// Packets and tuples pair strictly in arrival order.
module tuser_out_fsm
  import tuser_pkg::*;
#(
  parameter int unsigned DATA_W      = tuser_pkg::DATA_W,
  parameter int unsigned KEEP_W      = tuser_pkg::KEEP_W,
  parameter int unsigned TUSER_W     = tuser_pkg::TUSER_W,
  parameter int unsigned TUPLE_DEPTH = 4
) (
  input  logic               tout_aclk,
  input  logic               tout_arst,
  input  logic               tout_avalid,
  output logic               tout_aready,
  input  logic [DATA_W-1:0]  tout_adata,
  input  logic [KEEP_W-1:0]  tout_akeep,
  input  logic               tout_atlast,
  input  logic               tout_tvalid,
  input  logic [TUSER_W-1:0] tout_tdata,
  output logic               tout_bvalid,
  input  logic               tout_bready,
  output logic [DATA_W-1:0]  tout_bdata,
  output logic [KEEP_W-1:0]  tout_bkeep,
  output logic               tout_btlast,
  output logic [TUSER_W-1:0] tout_btuser,
  output logic [15:0]        tout_drop_cnt,
  output logic               tout_ovf,
  output logic [2:0]         dbg_state
);

  localparam int unsigned CW = ((TUPLE_DEPTH > 1) ? $clog2(TUPLE_DEPTH) : 1) + 1;

  logic [2:0]         state_q, state_d;
  logic               bvalid_q, bvalid_d;
  logic [DATA_W-1:0]  bdata_q, bdata_d;
  logic [KEEP_W-1:0]  bkeep_q, bkeep_d;
  logic               btlast_q, btlast_d;
  logic [TUSER_W-1:0] btuser_q, btuser_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;

  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count, count_next;
  logic [TUSER_W-1:0] fifo_rdata;
  logic               aready, xfer, is_head, pop, push_ok, drop, more_tuples;

  tuple_fifo #(
    .WIDTH (TUSER_W),
    .DEPTH (TUPLE_DEPTH)
  ) u_tuple_fifo (
    .clk   (tout_aclk),
    .rst   (tout_arst),
    .push  (tout_tvalid),
    .pop   (pop),
    .wdata (tout_tdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready, transfer qualification and tuple bookkeeping; ready never looks at tout_avalid.
  always_comb begin
    aready  = st_is_active(state_q) && (!bvalid_q || tout_bready);
    xfer    = tout_avalid && aready;
    is_head = (state_q == ST_HEAD);
    pop     = xfer && is_head && !fifo_empty;
    push_ok = tout_tvalid && (!fifo_full || pop);
    drop    = tout_tvalid && !push_ok;
    // Occupancy after this cycle's pop and push decides HEAD vs WAIT.
    count_next  = fifo_count - CW'(pop) + CW'(push_ok);
    more_tuples = (count_next != '0);
  end

  // Next-state logic; unused encodings fall back to WAIT behaviour.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HEAD, ST_BODY: begin
        if (xfer) begin
          if (tout_atlast) begin
            state_d = more_tuples ? ST_HEAD : ST_WAIT;
          end else begin
            state_d = ST_BODY;
          end
        end
      end
      default: begin
        state_d = more_tuples ? ST_HEAD : ST_WAIT;
      end
    endcase
  end

  // Output register next-state: load on transfer, drop valid once consumed, else hold.
  always_comb begin
    bvalid_d = bvalid_q;
    bdata_d  = bdata_q;
    bkeep_d  = bkeep_q;
    btlast_d = btlast_q;
    btuser_d = btuser_q;
    if (xfer) begin
      bvalid_d = 1'b1;
      bdata_d  = tout_adata;
      bkeep_d  = tout_akeep;
      btlast_d = tout_atlast;
      btuser_d = is_head ? fifo_rdata : '0;
    end else if (tout_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Saturating drop counter and sticky overflow flag.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    ovf_d = ovf_q | drop;
  end

  // All state registers; reset clears every output immediately.
  always_ff @(posedge tout_aclk or posedge tout_arst) begin
    if (tout_arst) begin
      state_q    <= ST_WAIT;
      bvalid_q   <= 1'b0;
      bdata_q    <= '0;
      bkeep_q    <= '0;
      btlast_q   <= 1'b0;
      btuser_q   <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bvalid_q   <= bvalid_d;
      bdata_q    <= bdata_d;
      bkeep_q    <= bkeep_d;
      btlast_q   <= btlast_d;
      btuser_q   <= btuser_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tout_aready   = aready;
  assign tout_bvalid   = bvalid_q;
  assign tout_bdata    = bdata_q;
  assign tout_bkeep    = bkeep_q;
  assign tout_btlast   = btlast_q;
  assign tout_btuser   = btuser_q;
  assign tout_drop_cnt = drop_cnt_q;
  assign tout_ovf      = ovf_q;
  assign dbg_state     = state_q;

endmodule
